// File: rtl/memoria_operandos_pkg.sv
// Shared constants for the operand memory: power-up table, default width and
// the address successor used by the scan pointer.
package memoria_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned INIT_WORDS = 8;

    // Index 0 is the leftmost word.
    localparam logic [0:INIT_WORDS-1][31:0] MEM_INIT = {
        32'hFF00_FF00, 32'h350F_6993, 32'h8000_0000, 32'h0000_0000,
        32'h0000_0001, 32'h0000_0008, 32'h0000_001F, 32'h0000_0000
    };

    function automatic int unsigned dir_siguiente(input int unsigned dir,
                                                  input int unsigned depth);
        return (dir + 1) % depth;
    endfunction

endpackage

// File: rtl/memoria_operandos_divisor_escaneo.sv
// Scan prescaler: counts 0..SCAN_DIV-1 while enabled and flags the terminal count.
module divisor_escaneo #(
    parameter int unsigned SCAN_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    // A clear in the same cycle wins over the terminal count.
    assign tick_o = en_i && !clr_i && (cnt == TC);

    always_ff @(posedge clk_i) begin
        if (clr_i)
            cnt <= '0;
        else if (en_i)
            cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/memoria_operandos.sv
// Dual-read operand memory with write-first bypass and a prescaled auto-scan
// mode that walks consecutive address pairs.
module memoria_operandos
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned SCAN_DIV = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    input  logic              scan_en_i,
    output logic [DATA_W-1:0] opa_o,
    output logic [DATA_W-1:0] opb_o,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic              valid_o,
    output logic              step_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t v;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < INIT_WORDS)
                v[i] = DATA_W'(MEM_INIT[i[2:0]]);
            else
                v[i] = '0;
        end
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] siguiente(input logic [ADDR_W-1:0] dir);
        return ADDR_W'(dir_siguiente(32'(dir), DEPTH));
    endfunction

    // Contents come from the table at configuration time only; reset leaves them alone.
    mem_t mem = init_mem();

    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W-1:0] ea, eb;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              scan_q;
    logic              entry;
    logic              tick;
    logic              presc_clr;

    // scan_q resets high so scan already held across reset is not an entry.
    assign entry     = scan_en_i && !scan_q;
    assign presc_clr = !rst_n_i || entry || !scan_en_i;

    divisor_escaneo #(
        .SCAN_DIV(SCAN_DIV)
    ) u_divisor (
        .clk_i (clk_i),
        .clr_i (presc_clr),
        .en_i  (scan_en_i),
        .tick_o(tick)
    );

    // The advanced pointer drives the read addresses in the same cycle, so the
    // new pair and step_o land together one edge later.
    always_comb begin
        ptr_nxt = ptr;
        if (scan_en_i) begin
            if (entry)
                ptr_nxt = raddr_a_i;
            else if (tick)
                ptr_nxt = siguiente(ptr);
        end
        ea = scan_en_i ? ptr_nxt : raddr_a_i;
        eb = scan_en_i ? siguiente(ptr_nxt) : raddr_b_i;
    end

    always_comb begin
        rd_a = mem[ea];
        rd_b = mem[eb];
        if (we_i && (waddr_i == ea))
            rd_a = wdata_i;
        if (we_i && (waddr_i == eb))
            rd_b = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && we_i)
            mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr      <= '0;
            scan_q   <= 1'b1;
            opa_o    <= '0;
            opb_o    <= '0;
            addr_a_o <= '0;
            addr_b_o <= '0;
            valid_o  <= 1'b0;
            step_o   <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            scan_q   <= scan_en_i;
            opa_o    <= rd_a;
            opb_o    <= rd_b;
            addr_a_o <= ea;
            addr_b_o <= eb;
            valid_o  <= 1'b1;
            step_o   <= scan_en_i && !entry && tick;
        end
    end

endmodule

// File: tb/tb_memoria_operandos.sv
// Directed bench: reset, manual reads, bypass, scan stepping/wrap, reset and
// exit during scan, and a 16-deep / 16-bit instance with SCAN_DIV=1.
module tb_memoria_operandos;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic        scan_en;
    logic [31:0] opa, opb;
    logic [2:0]  addr_a, addr_b;
    logic        valid, step;

    logic [3:0]  raddr2_a, raddr2_b;
    logic        scan_en2;
    logic [15:0] opa2, opb2;
    logic [3:0]  addr2_a, addr2_b;
    logic        valid2, step2;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memoria_operandos #(.DATA_W(32), .ADDR_W(3), .SCAN_DIV(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .scan_en_i(scan_en),
        .opa_o(opa), .opb_o(opb), .addr_a_o(addr_a), .addr_b_o(addr_b),
        .valid_o(valid), .step_o(step)
    );

    memoria_operandos #(.DATA_W(16), .ADDR_W(4), .SCAN_DIV(1)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .we_i(1'b0), .waddr_i(4'd0), .wdata_i(16'd0),
        .raddr_a_i(raddr2_a), .raddr_b_i(raddr2_b), .scan_en_i(scan_en2),
        .opa_o(opa2), .opb_o(opb2), .addr_a_o(addr2_a), .addr_b_o(addr2_b),
        .valid_o(valid2), .step_o(step2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                           input logic [31:0] da, input logic [31:0] db, input logic st);
        chk({tag, ".addr_a"}, 64'(addr_a), 64'(ea));
        chk({tag, ".addr_b"}, 64'(addr_b), 64'(eb));
        chk({tag, ".opa"}, 64'(opa), 64'(da));
        chk({tag, ".opb"}, 64'(opb), 64'(db));
        chk({tag, ".step"}, 64'(step), 64'(st));
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = 3'd1; raddr_b = 3'd2; scan_en = 1'b0;
        raddr2_a = 4'd9; raddr2_b = 4'd0; scan_en2 = 1'b0;

        edge1();
        edge1();
        chk_out("rst", 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("rst.valid", 64'(valid), 64'd0);

        rst_n = 1'b1;
        edge1();
        chk_out("man12", 3'd1, 3'd2, 32'h350F6993, 32'h80000000, 1'b0);
        chk("man12.valid", 64'(valid), 64'd1);
        chk("d2.entry9", 64'(opa2), 64'h0);
        chk("d2.entry0", 64'(opb2), 64'hFF00);

        // Write with both ports reading the same address: both bypass.
        we = 1'b1; waddr = 3'd3; wdata = 32'hDEADBEEF; raddr_a = 3'd3; raddr_b = 3'd3;
        edge1();
        chk_out("bypass", 3'd3, 3'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        we = 1'b0; raddr_a = 3'd0; raddr_b = 3'd3;
        edge1();
        chk_out("readback", 3'd0, 3'd3, 32'hFF00FF00, 32'hDEADBEEF, 1'b0);

        // Write attempted during reset must be dropped.
        rst_n = 1'b0; we = 1'b1; waddr = 3'd4; wdata = 32'h12345678;
        edge1();
        chk("rstwr.opa", 64'(opa), 64'h0);
        chk("rstwr.valid", 64'(valid), 64'd0);
        rst_n = 1'b1; we = 1'b0; raddr_a = 3'd4; raddr_b = 3'd5;
        edge1();
        chk_out("rstwr.read", 3'd4, 3'd5, 32'h00000001, 32'h00000008, 1'b0);

        // Scan entry at 6: (6,7) x4, (7,0) x4, (0,1).
        raddr_a = 3'd6; scan_en = 1'b1;
        edge1();
        chk_out("scan.entry", 3'd6, 3'd7, 32'h0000001F, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out("scan.hold67", 3'd6, 3'd7, 32'h0000001F, 32'h0, 1'b0);
        end
        edge1();
        chk_out("scan.wrap70", 3'd7, 3'd0, 32'h0, 32'hFF00FF00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out("scan.hold70", 3'd7, 3'd0, 32'h0, 32'hFF00FF00, 1'b0);
        end
        edge1();
        chk_out("scan.01", 3'd0, 3'd1, 32'hFF00FF00, 32'h350F6993, 1'b1);
        edge1();

        // Mid-count reset with scan held: pointer restarts at 0.
        rst_n = 1'b0;
        edge1();
        chk_out("scanrst", 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("scanrst.valid", 64'(valid), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out("scanrst.hold01", 3'd0, 3'd1, 32'hFF00FF00, 32'h350F6993, 1'b0);
        end
        chk("scanrst.valid1", 64'(valid), 64'd1);
        edge1();
        chk_out("scanrst.12", 3'd1, 3'd2, 32'h350F6993, 32'h80000000, 1'b1);

        // Exit: manual addresses immediately, no step.
        scan_en = 1'b0; raddr_a = 3'd4; raddr_b = 3'd5;
        edge1();
        chk_out("exit", 3'd4, 3'd5, 32'h00000001, 32'h00000008, 1'b0);

        // Wide-address instance, one step per cycle, wrap 15 -> 0.
        raddr2_a = 4'd14; scan_en2 = 1'b1;
        edge1();
        chk("d2.e.addr_a", 64'(addr2_a), 64'd14);
        chk("d2.e.addr_b", 64'(addr2_b), 64'd15);
        chk("d2.e.step", 64'(step2), 64'd0);
        edge1();
        chk("d2.w.addr_a", 64'(addr2_a), 64'd15);
        chk("d2.w.addr_b", 64'(addr2_b), 64'd0);
        chk("d2.w.opa", 64'(opa2), 64'h0);
        chk("d2.w.opb", 64'(opb2), 64'hFF00);
        chk("d2.w.step", 64'(step2), 64'd1);
        edge1();
        chk("d2.n.opa", 64'(opa2), 64'hFF00);
        chk("d2.n.opb", 64'(opb2), 64'h6993);
        chk("d2.n.step", 64'(step2), 64'd1);
        chk("d2.valid", 64'(valid2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/memoria_operandos.md
# memoria_operandos

Parametrised operand memory feeding both ALU operand buses. Holds DEPTH words of DATA_W bits with a synchronous write port and two registered read ports (operand A and B). Adds an auto-scan mode that steps through address pairs at a prescaled rate, so the board can cycle test vectors without switches. Sits between the switch/loader logic and the ALU inputs, replacing the fixed single-port operand ROM.

## Interface
- DATA_W, 32, word width
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W
- SCAN_DIV, 50_000_000, clock cycles per scan step; must be ≥ 1

- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- we_i  in  1  write enable
- waddr_i  in  ADDR_W  write address
- wdata_i  in  DATA_W  write data
- raddr_a_i  in  ADDR_W  manual read address, operand A
- raddr_b_i  in  ADDR_W  manual read address, operand B
- scan_en_i  in  1  1 = auto-scan mode, 0 = manual
- opa_o  out  DATA_W  operand A (registered)
- opb_o  out  DATA_W  operand B (registered)
- addr_a_o  out  ADDR_W  address currently shown on opa_o
- addr_b_o  out  ADDR_W  address currently shown on opb_o
- valid_o  out  1  operands valid
- step_o  out  1  one-cycle pulse: new scan pair visible on outputs

## Operation
- Array contents: power-up initialised from MEM_INIT (package); entries ≥ 8 initialise to 0. Reset never alters the array.
- Write: when we_i=1 and rst_n_i=1, mem[waddr_i] ← wdata_i at the clock edge.
- Manual mode (scan_en_i=0): each cycle, effective addresses EA=raddr_a_i, EB=raddr_b_i.
- Scan mode (scan_en_i=1): internal pointer ptr; EA=ptr, EB=(ptr+1) mod DEPTH. Prescaler counts 0..SCAN_DIV-1; on terminal count ptr ← (ptr+1) mod DEPTH (DEPTH-1 wraps to 0) and prescaler → 0.
- Mode entry (scan_en_i 0→1 sampled): ptr ← raddr_a_i, prescaler ← 0. Mode exit: ptr holds; manual addresses take effect immediately.
- Read: every cycle opa_o ← mem[EA], opb_o ← mem[EB], addr_a_o ← EA, addr_b_o ← EB.
- Write-first bypass: if we_i=1 and waddr_i equals EA (or EB) in the same cycle, that output registers wdata_i. EA=EB both bypass.
- valid_o: 0 during reset, 1 from the first edge after reset release onward.
- step_o: 1 for exactly the cycle in which outputs first show a pair produced by a ptr advance; never in manual mode, never on mode entry.

## Timing
- Read latency 1 cycle: address presented at edge n, data on outputs after edge n+1.
- Write visible to a later read the following cycle; same-cycle read via bypass.
- Scan: with scan_en held, ptr advances every SCAN_DIV cycles; SCAN_DIV=1 advances every cycle.
- Reset (rst_n_i=0 at edge): opa_o=0, opb_o=0, addr_a_o=0, addr_b_o=0, valid_o=0, step_o=0, ptr=0, prescaler=0; writes ignored. Mid-scan reset abandons count; scan restarts per mode-entry rule only after scan_en_i is seen 0→1 or is already 1 after reset (then ptr starts at 0).
- Prescaler width $clog2(SCAN_DIV), minimum 1 bit; no overflow beyond terminal count.

## Structure
- Package memoria_pkg: MEM_INIT table (8×32: FF00FF00, 350F6993, 80000000, 00000000, 00000001, 00000008, 0000001F, 00000000), DATA_W default, helper for (ptr+1) mod DEPTH.
- Sub-module divisor_escaneo: parametrised prescaler (SCAN_DIV) with sync clear, enable, one-cycle tick output.
- Top holds array, bypass muxes, ptr, output registers.

## Test plan
- Reset release, manual, raddr_a=1, raddr_b=2 -> after 1 cycle opa_o=350F6993, opb_o=80000000, valid_o=1; during reset all outputs 0.
- Write mem[3]=DEADBEEF with raddr_a=3 same cycle -> opa_o=DEADBEEF next cycle (bypass); read again later -> DEADBEEF.
- SCAN_DIV=4, raddr_a=6, scan_en 0→1 -> pairs (6,7),(7,0),(0,1) each held 4 cycles, step_o pulses on each change, wrap 7→0 correct.
- Scan running, rst_n_i=0 for 1 cycle mid-count -> outputs 0, valid_o=0, then with scan_en=1 ptr restarts at 0, first step after 4 cycles.
- Scan running, scan_en 1→0 with raddr_a=4, raddr_b=5 -> next cycle opa_o=00000001, opb_o=00000008, no step_o.
- ADDR_W=4, DATA_W=16 elaboration -> entries 8..15 read 0, wrap 15→0 in scan.
